keypad_scan: RTL and testbench



---
 rtl/keypad_scan.sv | 207 ++++++++++++++++++++
 tb/tb_keypad_scan.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low key matrix scanner with per-frame debounce and an event FIFO.
// Define KEYPAD_RELEASE_EN to also queue key-release events (key_release = 1).
module keypad_scan #(
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cols_n,
  output logic [3:0] rows_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_release,
  input  logic       key_ready,
  output logic       overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [3:0] cols_meta_q, cols_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_meta_q <= 4'hF;
      cols_sync_q <= 4'hF;
    end else begin
      cols_meta_q <= cols_n;
      cols_sync_q <= cols_meta_q;
    end
  end

  // Scan: run_q keeps all rows released until the first clock after reset.
  logic        run_q, run_d;
  logic [1:0]  row_q, row_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [15:0] raw_q, raw_d;
  logic        sample, frame_end;

  always_comb begin
    run_d     = 1'b1;
    row_d     = row_q;
    dwell_d   = dwell_q;
    raw_d     = raw_q;
    sample    = run_q && (dwell_q == 8'(SETTLE - 1));
    frame_end = sample && (row_q == 2'd3);
    if (run_q) begin
      if (sample) begin
        dwell_d                    = '0;
        row_d                      = row_q + 2'd1;
        raw_d[{row_q, 2'b00} +: 4] = ~cols_sync_q;
      end else begin
        dwell_d = dwell_q + 8'd1;
      end
    end
    rows_n = run_q ? ~(4'b0001 << row_q) : 4'hF;
  end

  logic [15:0] snap_q, snap_d, stable_q, stable_d, press_new;
  logic [3:0]  run_cnt_q, run_cnt_d;
`ifdef KEYPAD_RELEASE_EN
  logic [15:0] rel_new;
`endif

  // raw_d already holds row 3 on the frame-end clock, so it is the complete snapshot.
  always_comb begin
    snap_d    = snap_q;
    stable_d  = stable_q;
    run_cnt_d = run_cnt_q;
    press_new = '0;
`ifdef KEYPAD_RELEASE_EN
    rel_new   = '0;
`endif
    if (frame_end) begin
      snap_d = raw_d;
      if (raw_d == snap_q) begin
        run_cnt_d = (run_cnt_q == 4'hF) ? run_cnt_q : run_cnt_q + 4'd1;
      end else begin
        run_cnt_d = '0;
      end
      if ((run_cnt_d == 4'(DEBOUNCE - 1)) && (raw_d != stable_q)) begin
        press_new = raw_d & ~stable_q;
`ifdef KEYPAD_RELEASE_EN
        rel_new   = stable_q & ~raw_d;
`endif
        stable_d  = raw_d;
      end
    end
  end

  // Emitter: one event per clock, lowest pending press first, then lowest release.
  logic [15:0] press_pend_q, press_pend_d;
  logic        push_valid;
  logic [3:0]  push_code;
`ifdef KEYPAD_RELEASE_EN
  logic [15:0] rel_pend_q, rel_pend_d;
  logic        push_rel;
`endif

  always_comb begin
    push_valid   = 1'b0;
    push_code    = '0;
    press_pend_d = press_pend_q;
`ifdef KEYPAD_RELEASE_EN
    push_rel     = 1'b0;
    rel_pend_d   = rel_pend_q;
`endif
    for (int i = 15; i >= 0; i--) begin
      if (press_pend_q[i]) begin
        push_valid = 1'b1;
        push_code  = 4'(i);
      end
    end
    if (push_valid) begin
      press_pend_d[push_code] = 1'b0;
    end
`ifdef KEYPAD_RELEASE_EN
    else begin
      for (int i = 15; i >= 0; i--) begin
        if (rel_pend_q[i]) begin
          push_valid = 1'b1;
          push_rel   = 1'b1;
          push_code  = 4'(i);
        end
      end
      if (push_valid) begin
        rel_pend_d[push_code] = 1'b0;
      end
    end
    rel_pend_d = rel_pend_d | rel_new;
`endif
    press_pend_d = press_pend_d | press_new;
  end

  logic [3:0]      mem_code_q [FIFO_DEPTH];
`ifdef KEYPAD_RELEASE_EN
  logic            mem_rel_q  [FIFO_DEPTH];
`endif
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, pop, push;

  assign key_valid = (count_q != '0);

  // A full queue still takes a push when the head leaves in the same cycle.
  always_comb begin
    full     = (count_q == CntW'(FIFO_DEPTH));
    pop      = key_valid && key_ready;
    push     = push_valid && (!full || pop);
    overflow = push_valid && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    key_code = key_valid ? mem_code_q[rd_ptr_q] : '0;
  end

`ifdef KEYPAD_RELEASE_EN
  assign key_release = key_valid ? mem_rel_q[rd_ptr_q] : 1'b0;
`else
  assign key_release = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_code_q[wr_ptr_q] <= push_code;
`ifdef KEYPAD_RELEASE_EN
      mem_rel_q[wr_ptr_q]  <= push_rel;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      row_q        <= '0;
      dwell_q      <= '0;
      raw_q        <= '0;
      snap_q       <= '0;
      stable_q     <= '0;
      run_cnt_q    <= '0;
      press_pend_q <= '0;
`ifdef KEYPAD_RELEASE_EN
      rel_pend_q   <= '0;
`endif
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      run_q        <= run_d;
      row_q        <= row_d;
      dwell_q      <= dwell_d;
      raw_q        <= raw_d;
      snap_q       <= snap_d;
      stable_q     <= stable_d;
      run_cnt_q    <= run_cnt_d;
      press_pend_q <= press_pend_d;
`ifdef KEYPAD_RELEASE_EN
      rel_pend_q   <= rel_pend_d;
`endif
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a key-matrix model drives cols_n from rows_n and held keys.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cols_n, rows_n, key_code;
  logic        key_valid, key_release, key_ready, overflow;
  logic [15:0] keys;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          first_valid = -1;
  int          ovf_cnt = 0;
  bit          rel_seen = 1'b0;
  logic [4:0]  ev_q [$];

  always #5 clk = ~clk;

  always_comb begin
    cols_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rows_n[r] && keys[r*4+c]) cols_n[c] = 1'b0;
      end
    end
  end

  keypad_scan #(
    .SETTLE    (4),
    .DEBOUNCE  (3),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cols_n     (cols_n),
    .rows_n     (rows_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_release(key_release),
    .key_ready  (key_ready),
    .overflow   (overflow)
  );

  // Observe the current cycle just after the negedge, then advance to the next negedge.
  task automatic tick();
    #1;
    if (rst_n) begin
      if (key_valid && key_ready) ev_q.push_back({key_release, key_code});
      if (key_valid && first_valid < 0) first_valid = cyc;
      if (overflow) ovf_cnt++;
      if (key_valid && key_release) rel_seen = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_frames(input int n);
    repeat (n * 16) tick();
  endtask

  task automatic sync_frame();
    logic [3:0] prev;
    bit         found;
    found = 1'b0;
    prev  = rows_n;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (rows_n == 4'hE && prev != 4'hE) found = 1'b1;
      prev = rows_n;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL frame_sync: rows_n=%h, required a frame start within 40 clocks", rows_n);
    end
  endtask

  task automatic idle();
    keys      = '0;
    key_ready = 1'b1;
    wait_frames(6);
    ev_q.delete();
    ovf_cnt     = 0;
    first_valid = -1;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n     = 1'b0;
    keys      = '0;
    key_ready = 1'b1;
    tick();
    tick();
    n_tests += 5;
    if (rows_n !== 4'hF) begin n_fail++; $display("FAIL reset_rows: got %h want F", rows_n); end
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h want 0", key_code); end
    if (key_release !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got %b want 0", key_release);
    end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      exp = ~(4'b0001 << (k / 4));
      n_tests++;
      if (rows_n !== exp) begin
        n_fail++; $display("FAIL row_walk[%0d]: got %h want %h", k, rows_n, exp);
      end
      tick();
    end
  endtask

  task automatic test_single_press();
    int         t0;
    int         lat;
    logic [4:0] ev;
    sync_frame();
    t0          = cyc;
    first_valid = -1;
    keys        = 16'h0040;
    wait_frames(10);
    lat = first_valid - t0;
    ev  = ev_q[0];
    n_tests += 3;
    if (ev_q.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d events want 1", ev_q.size());
    end
    if (ev !== 5'h06) begin n_fail++; $display("FAIL single_event: got %h want 06", ev); end
    if (first_valid < 0 || lat < 48 || lat > 51) begin
      n_fail++; $display("FAIL single_latency: got %0d clocks want 48..51", lat);
    end
    keys = '0;
    wait_frames(6);
    n_tests++;
`ifdef KEYPAD_RELEASE_EN
    ev = ev_q[1];
    if (ev_q.size() != 2 || ev !== 5'h16) begin
      n_fail++; $display("FAIL single_release: got %0d events, second %h want 2, 16", ev_q.size(), ev);
    end
`else
    if (ev_q.size() != 1) begin
      n_fail++; $display("FAIL single_after_release: got %0d events want 1", ev_q.size());
    end
`endif
    idle();
  endtask

  task automatic test_bounce();
    logic [4:0] ev;
    sync_frame();
    keys = 16'h0200; wait_frames(2);
    keys = 16'h0000; wait_frames(1);
    keys = 16'h0200; wait_frames(2);
    keys = 16'h0000; wait_frames(4);
    n_tests++;
    if (ev_q.size() != 0) begin
      n_fail++; $display("FAIL bounce_reject: got %0d events want 0", ev_q.size());
    end
    sync_frame();
    keys = 16'h0200; wait_frames(3);
    keys = 16'h0000; wait_frames(6);
    ev = ev_q[0];
    n_tests += 2;
    if (ev !== 5'h09) begin n_fail++; $display("FAIL bounce_accept: got %h want 09", ev); end
`ifdef KEYPAD_RELEASE_EN
    if (ev_q.size() != 2) begin
      n_fail++; $display("FAIL bounce_count: got %0d events want 2", ev_q.size());
    end
`else
    if (ev_q.size() != 1) begin
      n_fail++; $display("FAIL bounce_count: got %0d events want 1", ev_q.size());
    end
`endif
    idle();
  endtask

  task automatic test_simultaneous();
    logic [4:0] ev0, ev1;
    sync_frame();
    keys = 16'h1008;
    wait_frames(6);
    ev0 = ev_q[0];
    ev1 = ev_q[1];
    n_tests += 3;
    if (ev_q.size() != 2) begin
      n_fail++; $display("FAIL simul_count: got %0d events want 2", ev_q.size());
    end
    if (ev0 !== 5'h03) begin n_fail++; $display("FAIL simul_first: got %h want 03", ev0); end
    if (ev1 !== 5'h0C) begin n_fail++; $display("FAIL simul_second: got %h want 0C", ev1); end
    idle();
  endtask

  task automatic test_overflow();
    logic [4:0] ev;
    key_ready = 1'b0;
    sync_frame();
    keys = 16'h001F;
    wait_frames(5);
    n_tests += 4;
    if (ovf_cnt != 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d cycles want 1", ovf_cnt); end
    if (key_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", key_valid); end
    if (key_code !== 4'h0) begin n_fail++; $display("FAIL ovf_head: got %h want 0", key_code); end
    if (ev_q.size() != 0) begin
      n_fail++; $display("FAIL ovf_no_pop: got %0d pops want 0", ev_q.size());
    end
    key_ready = 1'b1;
    wait_frames(1);
    n_tests += 2;
    if (ev_q.size() != 4) begin
      n_fail++; $display("FAIL ovf_drain_count: got %0d events want 4", ev_q.size());
    end
    if (key_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drain_empty: got valid %b want 0", key_valid);
    end
    for (int i = 0; i < 4; i++) begin
      ev = ev_q[i];
      n_tests++;
      if (ev !== 5'(i)) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h want %h", i, ev, 5'(i)); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [4:0] ev;
    key_ready = 1'b0;
    sync_frame();
    keys = 16'h0420;
    wait_frames(5);
    n_tests += 2;
    if (key_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b want 1", key_valid); end
    if (key_code !== 4'h5) begin n_fail++; $display("FAIL rmid_pre_head: got %h want 5", key_code); end
    rst_n = 1'b0;
    #1;
    n_tests += 3;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", key_valid); end
    if (rows_n !== 4'hF) begin n_fail++; $display("FAIL rmid_rows: got %h want F", rows_n); end
    if (key_code !== 4'h0) begin n_fail++; $display("FAIL rmid_code: got %h want 0", key_code); end
    keys = 16'h0020;
    repeat (3) tick();
    rst_n     = 1'b1;
    key_ready = 1'b1;
    wait_frames(6);
    ev = ev_q[0];
    n_tests += 2;
    if (ev_q.size() != 1) begin
      n_fail++; $display("FAIL rmid_count: got %0d events want 1", ev_q.size());
    end
    if (ev !== 5'h05) begin n_fail++; $display("FAIL rmid_event: got %h want 05", ev); end
    idle();
  endtask

  task automatic test_release();
    logic [4:0] ev0, ev1;
    sync_frame();
    keys = 16'h8000;
    wait_frames(5);
    keys = 16'h0000;
    wait_frames(6);
    ev0 = ev_q[0];
    ev1 = ev_q[1];
    n_tests += 2;
    if (ev0 !== 5'h0F) begin n_fail++; $display("FAIL rel_press: got %h want 0F", ev0); end
`ifdef KEYPAD_RELEASE_EN
    if (ev_q.size() != 2 || ev1 !== 5'h1F) begin
      n_fail++; $display("FAIL rel_event: got %0d events, second %h want 2, 1F", ev_q.size(), ev1);
    end
`else
    if (ev_q.size() != 1 || rel_seen) begin
      n_fail++;
      $display("FAIL rel_absent: got %0d events rel_seen=%b want 1, 0 (second %h)",
               ev_q.size(), rel_seen, ev1);
    end
`endif
    idle();
  endtask

  initial begin
    test_reset();
    idle();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_release();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
